// File: rtl/ssd_pkg.sv
// -----------------------------------------------------------------------------
// ssd_pkg
// Shared definitions for the seven-segment scan decoder:
//   - STABLE_CYCLES_DEFAULT : default dwell length before a digit is accepted
//   - state_t               : scan FSM state encoding
//   - sample_t              : one synchronised snapshot of the display lines
//   - SEG_CODE              : active-low cathode pattern for each hex value
// -----------------------------------------------------------------------------
package ssd_pkg;

  localparam int STABLE_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no single anode selected
    SETTLE = 2'd1,  // one anode low, waiting for the lines to stay put
    HELD   = 2'd2   // this dwell has already been evaluated
  } state_t;

  // Field order matches the raw line order {An3..An0, Ca..Cg, Dp}.
  typedef struct packed {
    logic [3:0] an;   // an[i] is the active-low select for digit i
    logic [6:0] seg;  // {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, Ca in the MSB
    logic       dp;   // active-low decimal point
  } sample_t;

  // Active-low segment patterns, indexed by the hex value they display.
  localparam logic [0:15][6:0] SEG_CODE = {
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0001100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/ssd_cathode_to_hex.sv
// -----------------------------------------------------------------------------
// ssd_cathode_to_hex
// Combinational reverse lookup from an active-low segment pattern to the hex
// value it shows.
//   seg   : {Ca..Cg} active-low cathode levels
//   hex   : decoded value (0 when the pattern is not recognised)
//   legal : 1 when seg matches one of the 16 hex glyphs
// -----------------------------------------------------------------------------
module ssd_cathode_to_hex
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       legal
);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    hex   = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_CODE[i]) begin
        hex   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// -----------------------------------------------------------------------------
// ssd_scan_decoder
// Watches a multiplexed 4-digit seven-segment display bus and recovers the
// hex value and decimal point shown on each digit.
//   ClkPort      : system clock, rising edge
//   reset        : asynchronous active-high reset
//   An0..An3     : active-low anode selects (An0 = digit 0)
//   Ca..Cg, Dp   : active-low segment and decimal-point cathodes
//   dig0..dig3   : last accepted hex value per digit
//   dp_out       : last accepted decimal point per digit, 1 = lit
//   frame_valid  : one-cycle pulse once all four digits have been accepted
//   code_err     : one-cycle pulse on an unknown glyph or multiple anodes low
// A digit is accepted only after its lines have been identical for
// STABLE_CYCLES consecutive synchronised samples.
// -----------------------------------------------------------------------------
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       ClkPort,
  input  logic       reset,
  input  logic       An0,
  input  logic       An1,
  input  logic       An2,
  input  logic       An3,
  input  logic       Ca,
  input  logic       Cb,
  input  logic       Cc,
  input  logic       Cd,
  input  logic       Ce,
  input  logic       Cf,
  input  logic       Cg,
  input  logic       Dp,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dp_out,
  output logic       frame_valid,
  output logic       code_err
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser plus one-sample history for change detection
  // ---------------------------------------------------------------------------
  sample_t raw, sync1, sample, prev;

  assign raw = {An3, An2, An1, An0, Ca, Cb, Cc, Cd, Ce, Cf, Cg, Dp};

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, keeping the pipeline order intact.
  // Synchroniser flops reset to all-ones, which is the idle (blanked) bus.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      sync1  <= '1;
      sample <= '1;
      prev   <= '1;
    end else begin
      sync1  <= raw;
      sample <= sync1;
      prev   <= sample;
    end
  end

  // ---------------------------------------------------------------------------
  // Anode classification
  // ---------------------------------------------------------------------------
  logic [3:0] lows, prev_lows;
  logic       one_low, multi_low, prev_multi, changed;
  logic [1:0] sel;

  assign lows       = ~sample.an;
  assign prev_lows  = ~prev.an;
  // A nonzero vector with a single set bit clears when ANDed with itself - 1.
  assign one_low    = (lows != 4'b0) && ((lows & (lows - 4'd1)) == 4'b0);
  assign multi_low  = (lows != 4'b0) && !one_low;
  assign prev_multi = (prev_lows != 4'b0) &&
                      ((prev_lows & (prev_lows - 4'd1)) != 4'b0);
  assign changed    = (sample != prev);

  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lows[i]) sel = 2'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Glyph lookup
  // ---------------------------------------------------------------------------
  logic [3:0] hex;
  logic       legal;

  ssd_cathode_to_hex u_cathode_to_hex (
    .seg   (sample.seg),
    .hex   (hex),
    .legal (legal)
  );

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic       eval, multi_err;

  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    eval       = 1'b0;
    multi_err  = 1'b0;

    if (lows == 4'b0000) begin
      // Blanking interval: abandon any dwell without evaluating it.
      state_next = IDLE;
      cnt_next   = '0;
    end else if (multi_low) begin
      // Flag only the first sample of a multi-anode episode.
      state_next = IDLE;
      cnt_next   = '0;
      multi_err  = !prev_multi;
    end else begin
      unique case (state)
        IDLE: begin
          state_next = SETTLE;
          cnt_next   = '0;
        end
        SETTLE: begin
          if (changed) begin
            cnt_next = '0;
          end else begin
            cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
            // Evaluate on the edge where the count arrives at its last value,
            // so a steady input is captured 2 + STABLE_CYCLES edges after it
            // appears on the pins.
            if (cnt_next >= CNT_LAST) begin
              eval       = 1'b1;
              state_next = HELD;
            end
          end
        end
        HELD: begin
          if (changed) begin
            state_next = SETTLE;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Digit registers, capture mask and status pulses
  // ---------------------------------------------------------------------------
  logic [3:0] dig_q [4];
  logic [3:0] mask, mask_base;

  // A full mask is consumed by the frame_valid cycle; a capture landing in
  // that same cycle starts the next frame.
  assign mask_base = (mask == 4'hF) ? 4'h0 : mask;

  // NOTE: the digit registers are a tiny register file, not a RAM, and their
  // reset value is architecturally visible, so every entry is reset.
  always_ff @(posedge ClkPort or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) dig_q[i] <= 4'h0;
      dp_out      <= 4'b0000;
      mask        <= 4'b0000;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      frame_valid <= (mask == 4'hF);
      code_err    <= multi_err | (eval & !legal);
      if (eval && legal) begin
        dig_q[sel]  <= hex;
        dp_out[sel] <= ~sample.dp;
        mask        <= mask_base | (4'b0001 << sel);
      end else begin
        mask        <= mask_base;
      end
    end
  end

  assign dig0 = dig_q[0];
  assign dig1 = dig_q[1];
  assign dig2 = dig_q[2];
  assign dig3 = dig_q[3];

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_ssd_scan_decoder
// Directed bench for ssd_scan_decoder with STABLE_CYCLES = 16. Inputs change
// 1 ns after a rising edge; outputs are read 1 ns after a rising edge, and
// frame_valid / code_err pulses are counted on falling edges.
// -----------------------------------------------------------------------------
module tb_ssd_scan_decoder;

  logic       clk;
  logic       rst;
  logic [3:0] an;    // an[i] drives An<i>, active low
  logic [6:0] seg;   // {Ca..Cg}, active low
  logic       dp;
  logic [3:0] dig [4];
  logic [3:0] dp_out;
  logic       frame_valid;
  logic       code_err;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  logic [6:0] code_tab [16];

  ssd_scan_decoder #(.STABLE_CYCLES(16)) dut (
    .ClkPort     (clk),
    .reset       (rst),
    .An0         (an[0]),
    .An1         (an[1]),
    .An2         (an[2]),
    .An3         (an[3]),
    .Ca          (seg[6]),
    .Cb          (seg[5]),
    .Cc          (seg[4]),
    .Cd          (seg[3]),
    .Ce          (seg[2]),
    .Cf          (seg[1]),
    .Cg          (seg[0]),
    .Dp          (dp),
    .dig0        (dig[0]),
    .dig1        (dig[1]),
    .dig2        (dig[2]),
    .dig3        (dig[3]),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .code_err    (code_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (code_err === 1'b1) err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Hold the bus at the given levels for a number of clock edges; returns
  // 1 ns after the last edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d,
                       input int cycles);
    an  = a;
    seg = s;
    dp  = d;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic show(input int idx, input int val, input int cycles);
    logic [3:0] a;
    a = ~(4'b0001 << idx);
    drive(a, code_tab[val], 1'b1, cycles);
  endtask

  task automatic blank(input int cycles);
    drive(4'b1111, 7'b1111111, 1'b1, cycles);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    dp  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dig[i] !== 4'h0) begin
        n_err++;
        $display("FAIL reset_dig%0d: got %h, required 0", i, dig[i]);
      end
    end
    n_cmp++;
    if (dp_out !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_dp_out: got %b, required 0000", dp_out);
    end
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_frame_valid: got %b, required 0", frame_valid);
    end
    n_cmp++;
    if (code_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_code_err: got %b, required 0", code_err);
    end
    rst = 1'b0;
    blank(4);
  endtask

  task automatic test_normal_frame;
    int fv0, e0;
    logic [3:0] exp_dig [4];
    fv0 = fv_cnt;
    e0  = err_cnt;
    exp_dig[0] = 4'h1;
    exp_dig[1] = 4'h2;
    exp_dig[2] = 4'h3;
    exp_dig[3] = 4'h4;
    show(0, 1, 64);
    show(1, 2, 64);
    show(2, 3, 64);
    n_cmp++;
    if (fv_cnt - fv0 !== 0) begin
      n_err++;
      $display("FAIL frame_early: frame_valid pulses %0d before digit 3, required 0", fv_cnt - fv0);
    end
    show(3, 4, 64);
    blank(8);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dig[i] !== exp_dig[i]) begin
        n_err++;
        $display("FAIL frame_dig%0d: got %h, required %h", i, dig[i], exp_dig[i]);
      end
    end
    n_cmp++;
    if (fv_cnt - fv0 !== 1) begin
      n_err++;
      $display("FAIL frame_valid_count: got %0d pulses, required 1", fv_cnt - fv0);
    end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL frame_code_err: got %0d pulses, required 0", err_cnt - e0);
    end
    n_cmp++;
    if (dp_out !== 4'b0000) begin
      n_err++;
      $display("FAIL frame_dp_out: got %b, required 0000", dp_out);
    end
  endtask

  // Digit 0 is captured twice inside one frame; the later value wins and the
  // frame still completes exactly once.
  task automatic test_back_to_back;
    int fv0;
    logic [3:0] exp_dig [4];
    fv0 = fv_cnt;
    exp_dig[0] = 4'hE;
    exp_dig[1] = 4'hD;
    exp_dig[2] = 4'hF;
    exp_dig[3] = 4'h0;
    show(0, 12, 40);
    show(1, 13, 40);
    show(0, 14, 40);
    n_cmp++;
    if (fv_cnt - fv0 !== 0) begin
      n_err++;
      $display("FAIL b2b_early_frame: got %0d pulses, required 0", fv_cnt - fv0);
    end
    show(2, 15, 40);
    show(3, 0, 40);
    blank(8);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (dig[i] !== exp_dig[i]) begin
        n_err++;
        $display("FAIL b2b_dig%0d: got %h, required %h", i, dig[i], exp_dig[i]);
      end
    end
    n_cmp++;
    if (fv_cnt - fv0 !== 1) begin
      n_err++;
      $display("FAIL b2b_frame_count: got %0d pulses, required 1", fv_cnt - fv0);
    end
  endtask

  // Pins change just after edge 0; capture must land on edge 18.
  task automatic test_latency;
    blank(5);
    an  = 4'b1110;
    seg = code_tab[5];
    dp  = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    n_cmp++;
    if (dig[0] !== 4'hE) begin
      n_err++;
      $display("FAIL latency_edge17: dig0 got %h, required E", dig[0]);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (dig[0] !== 4'h5) begin
      n_err++;
      $display("FAIL latency_edge18: dig0 got %h, required 5", dig[0]);
    end
    repeat (20) @(posedge clk);
    #1;
    blank(5);
  endtask

  task automatic test_short_dwell;
    int e0;
    e0 = err_cnt;
    show(1, 7, 10);
    blank(20);
    n_cmp++;
    if (dig[1] !== 4'hD) begin
      n_err++;
      $display("FAIL short_dwell_dig1: got %h, required D", dig[1]);
    end
    n_cmp++;
    if (err_cnt - e0 !== 0) begin
      n_err++;
      $display("FAIL short_dwell_code_err: got %0d pulses, required 0", err_cnt - e0);
    end
  endtask

  task automatic test_illegal_code;
    int e0;
    e0 = err_cnt;
    drive(4'b1011, 7'b1111111, 1'b1, 40);
    blank(10);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL illegal_code_err: got %0d pulses, required 1", err_cnt - e0);
    end
    n_cmp++;
    if (dig[2] !== 4'hF) begin
      n_err++;
      $display("FAIL illegal_dig2: got %h, required F", dig[2]);
    end
  endtask

  task automatic test_multi_anode;
    int e0;
    e0 = err_cnt;
    drive(4'b0110, code_tab[8], 1'b1, 40);
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL multi_code_err: got %0d pulses, required 1", err_cnt - e0);
    end
    n_cmp++;
    if (dig[0] !== 4'h5) begin
      n_err++;
      $display("FAIL multi_dig0: got %h, required 5", dig[0]);
    end
    n_cmp++;
    if (dig[3] !== 4'h0) begin
      n_err++;
      $display("FAIL multi_dig3: got %h, required 0", dig[3]);
    end
    show(3, 9, 40);
    blank(5);
    n_cmp++;
    if (dig[3] !== 4'h9) begin
      n_err++;
      $display("FAIL multi_recover_dig3: got %h, required 9", dig[3]);
    end
    n_cmp++;
    if (err_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL multi_recover_code_err: got %0d pulses, required 1", err_cnt - e0);
    end
  endtask

  task automatic test_decimal_point;
    drive(4'b1110, code_tab[8], 1'b0, 40);
    blank(5);
    n_cmp++;
    if (dig[0] !== 4'h8) begin
      n_err++;
      $display("FAIL dp_dig0: got %h, required 8", dig[0]);
    end
    n_cmp++;
    if (dp_out !== 4'b0001) begin
      n_err++;
      $display("FAIL dp_out: got %b, required 0001", dp_out);
    end
  endtask

  task automatic test_reset_mid_frame;
    int fv0;
    show(0, 5, 40);
    show(1, 6, 40);
    show(2, 7, 40);
    // Partial dwell on digit 3, then reset with the pins left unchanged.
    show(3, 10, 10);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dig[0] !== 4'h0) begin
      n_err++;
      $display("FAIL midreset_dig0_during: got %h, required 0", dig[0]);
    end
    fv0 = fv_cnt;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (dig[3] !== 4'h0) begin
      n_err++;
      $display("FAIL midreset_early_capture: dig3 got %h, required 0", dig[3]);
    end
    repeat (30) @(posedge clk);
    #1;
    blank(8);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (dig[i] !== 4'h0) begin
        n_err++;
        $display("FAIL midreset_dig%0d: got %h, required 0", i, dig[i]);
      end
    end
    n_cmp++;
    if (dig[3] !== 4'hA) begin
      n_err++;
      $display("FAIL midreset_dig3: got %h, required A", dig[3]);
    end
    n_cmp++;
    if (fv_cnt - fv0 !== 0) begin
      n_err++;
      $display("FAIL midreset_frame_valid: got %0d pulses, required 0", fv_cnt - fv0);
    end
  endtask

  initial begin
    code_tab[0]  = 7'b0000001;
    code_tab[1]  = 7'b1001111;
    code_tab[2]  = 7'b0010010;
    code_tab[3]  = 7'b0000110;
    code_tab[4]  = 7'b1001100;
    code_tab[5]  = 7'b0100100;
    code_tab[6]  = 7'b0100000;
    code_tab[7]  = 7'b0001111;
    code_tab[8]  = 7'b0000000;
    code_tab[9]  = 7'b0001100;
    code_tab[10] = 7'b0001000;
    code_tab[11] = 7'b1100000;
    code_tab[12] = 7'b0110001;
    code_tab[13] = 7'b1000010;
    code_tab[14] = 7'b0110000;
    code_tab[15] = 7'b0111000;

    test_reset;
    test_normal_frame;
    test_back_to_back;
    test_latency;
    test_short_dwell;
    test_illegal_code;
    test_multi_anode;
    test_decimal_point;
    test_reset_mid_frame;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_scan_decoder.md
SSD_SCAN_DECODER -- requirements
Module: ssd_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, meaning consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 SHALL have port ClkPort, input, 1 bit, the single system clock; all logic is rising-edge triggered.
REQ-003 SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-004 SHALL have ports An0, An1, An2 and An3, each input, 1 bit, active-low anode selects; An0 selects digit 0 and An3 selects digit 3.
REQ-005 SHALL have ports Ca, Cb, Cc, Cd, Ce, Cf and Cg, each input, 1 bit, active-low segment cathodes.
REQ-006 SHALL have port Dp, input, 1 bit, the active-low decimal-point cathode.
REQ-007 SHALL have ports dig0, dig1, dig2 and dig3, each output, 4 bits, the last accepted hex value for digit 0..3.
REQ-008 SHALL have port dp_out, output, 4 bits, where bit i is the last accepted Dp level for digit i, inverted so that 1 means lit.
REQ-009 SHALL have port frame_valid, output, 1 bit, a one-cycle pulse when all four digits have been accepted since the previous pulse.
REQ-010 SHALL have port code_err, output, 1 bit, a one-cycle pulse when a stable sample carries an illegal segment pattern or more than one low anode.

Function
REQ-011 SHALL register all 12 inputs through two flop stages before any use; in the rest of this document, "sample" means the second-stage value.
REQ-012 SHALL form the segment code seg = {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, with Ca as the MSB.
REQ-013 SHALL decode seg as follows: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Any other seg value is illegal.
REQ-014 SHALL implement a state machine with three states:
- IDLE: no anode low.
- SETTLE: exactly one anode low; the stability counter is running.
- HELD: the current dwell has already been evaluated.
REQ-015 SHALL clear the stability counter and re-enter SETTLE whenever the 12-bit sample differs from the previous sample while exactly one anode is low.
- This applies from IDLE, SETTLE or HELD.
REQ-016 SHALL, in SETTLE, increment the counter on each unchanged sample; on the cycle the counter reaches STABLE_CYCLES-1, it SHALL evaluate the sample and go to HELD.
REQ-017 SHALL, on a legal evaluation, update the selected digit register and the selected dp_out bit, and set the corresponding bit of a 4-bit captured mask.
- The register update occurs on the clock edge 2+STABLE_CYCLES cycles after the input edge, for inputs held constant.
REQ-018 SHALL, on an illegal evaluation, pulse code_err for one cycle and leave the digit register, the dp_out bit and the captured mask unchanged.
REQ-019 SHALL go to IDLE with no evaluation when all anodes are high (blanking).
- The counter is cleared.
REQ-020 SHALL, when two or more anodes are low, pulse code_err once per such episode (on entry) and then stay in IDLE until exactly one anode is low.
REQ-021 SHALL evaluate at most once per dwell; while in HELD, re-evaluation requires a sample change.
REQ-022 SHALL assert frame_valid the cycle after the captured mask becomes 4'b1111, and SHALL clear the mask in that same cycle.
- A capture landing in the frame_valid cycle SHALL be counted toward the next frame.
REQ-023 SHALL accept a digit that is re-captured before the frame completes by overwriting its value; the mask bit simply remains set.
REQ-024 SHALL saturate the counter and never wrap it.

Reset
REQ-025 SHALL, while reset is high, immediately force:
- dig0..dig3 = 4'h0
- dp_out = 4'b0000
- frame_valid = 0
- code_err = 0
- captured mask = 0
- counter = 0
- sync flops = 1 (idle lines)
- state = IDLE
REQ-026 SHALL discard any dwell in progress when reset asserts mid-operation; after reset releases, no capture SHALL occur until a full fresh STABLE_CYCLES dwell is seen.

Structure
REQ-027 SHALL place the following in shared package ssd_pkg:
- the 16-entry cathode code constants
- the state encoding (IDLE, SETTLE, HELD)
- the STABLE_CYCLES default
REQ-028 SHALL implement the seg-to-hex lookup in one combinational sub-module, ssd_cathode_to_hex, with outputs hex[3:0] and legal.

Verification
REQ-029 SHALL verify a normal frame: drive the anodes 0..3 in turn, each for 64 cycles, with codes for 1, 2, 3, 4 -> dig0..dig3 = 1, 2, 3, 4, and one frame_valid pulse after digit 3.
REQ-030 SHALL verify short dwells: hold An1 low for 10 cycles with STABLE_CYCLES=16 -> dig1 unchanged and no code_err.
REQ-031 SHALL verify an illegal code: drive seg=1111111 on An2 for 40 cycles -> exactly one code_err pulse and dig2 unchanged.
REQ-032 SHALL verify a multi-anode fault: drive An0 and An3 low together -> one code_err pulse, then no captures until the condition clears.
REQ-033 SHALL verify reset mid-frame: capture three digits, pulse reset, then capture digit 3 -> no frame_valid and all dig outputs at 0 except dig3.
REQ-034 SHALL verify the decimal point: drive Dp=0 with code 8 on An0 -> dig0 = 8 and dp_out[0] = 1.
